// File: rtl/mac_pim_pkg.sv
// Shared types and default widths for the PIM MAC sequencer.
// Optional B-stride addressing is enabled by defining MAC_SEQ_STRIDE_EN.
package mac_pim_pkg;

  localparam int unsigned MAC_PIPE_DEPTH = 2;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_LEN_W  = 10;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_PSUM_W = 65;
  localparam int unsigned DEF_RD_LAT = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    CAPT  = 3'd4,
    DONE  = 3'd5
  } seq_state_e;

endpackage

// File: rtl/mac_seq_valid_pipe.sv
// Valid shift register that delays each read strobe into the MAC accumulate
// enable, and flags when no valid remains behind the tail stage.
module mac_seq_valid_pipe #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_valid,
  output logic o_next,
  output logic o_empty
);

  logic [DEPTH-1:0] r_pipe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= {r_pipe[DEPTH-2:0], i_valid};
    end
  end

  assign o_next = r_pipe[DEPTH-1];

  // Only the tail (if anything) is still live: it retires this cycle.
  assign o_empty = ~i_valid & ~(|r_pipe[DEPTH-2:0]);

endmodule

// File: rtl/mac_dot_sequencer.sv
// Dot-product command sequencer: reads operand pairs from SRAM, drives the
// 2-stage MAC, returns the final psum. MAC_SEQ_STRIDE_EN adds a B stride.
module mac_dot_sequencer
  import mac_pim_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LEN_W  = DEF_LEN_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned PSUM_W = DEF_PSUM_W,
  parameter int unsigned RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base_a,
  input  logic [ADDR_W-1:0] cmd_base_b,
  input  logic [LEN_W-1:0]  cmd_len,
`ifdef MAC_SEQ_STRIDE_EN
  input  logic [ADDR_W-1:0] cmd_stride_b,
`endif
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr_a,
  output logic [ADDR_W-1:0] mem_addr_b,
  input  logic [DATA_W-1:0] mem_rdata_a,
  input  logic [DATA_W-1:0] mem_rdata_b,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic              mac_clear,
  output logic              mac_next,
  input  logic [PSUM_W-1:0] mac_psum,
  output logic              res_valid,
  output logic [PSUM_W-1:0] res_data,
  input  logic              res_ready,
  output logic              busy
);

  localparam int unsigned VPIPE_DEPTH = RD_LAT + MAC_PIPE_DEPTH;

  seq_state_e        r_state;
  logic [ADDR_W-1:0] r_base_a;
  logic [ADDR_W-1:0] r_base_b;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_addr_a;
  logic [ADDR_W-1:0] r_addr_b;
  logic              r_clear;
  logic              r_res_valid;
  logic [PSUM_W-1:0] r_res_data;
  logic [ADDR_W-1:0] w_stride_b;
  logic              w_next;
  logic              w_empty;

`ifdef MAC_SEQ_STRIDE_EN
  logic [ADDR_W-1:0] r_stride_b;
  assign w_stride_b = r_stride_b;
`else
  assign w_stride_b = ADDR_W'(1);
`endif

  mac_seq_valid_pipe #(
    .DEPTH (VPIPE_DEPTH)
  ) u_valid_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .i_valid (r_mem_req),
    .o_next  (w_next),
    .o_empty (w_empty)
  );

  // Command FSM with registered strobes, addresses and result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_base_a    <= '0;
      r_base_b    <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_clear     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
`ifdef MAC_SEQ_STRIDE_EN
      r_stride_b  <= '0;
`endif
    end else begin
      r_clear <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_base_a   <= cmd_base_a;
            r_base_b   <= cmd_base_b;
            r_len      <= cmd_len;
`ifdef MAC_SEQ_STRIDE_EN
            r_stride_b <= cmd_stride_b;
`endif
            r_clear    <= 1'b1;
            r_state    <= CLEAR;
          end
        end
        CLEAR: begin
          if (r_len == '0) begin
            r_state <= CAPT;
          end else begin
            r_mem_req <= 1'b1;
            r_addr_a  <= r_base_a;
            r_addr_b  <= r_base_b;
            r_cnt     <= r_len - LEN_W'(1);
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_cnt == '0) begin
            r_mem_req <= 1'b0;
            r_state   <= DRAIN;
          end else begin
            r_addr_a <= r_addr_a + ADDR_W'(1);
            r_addr_b <= r_addr_b + w_stride_b;
            r_cnt    <= r_cnt - LEN_W'(1);
          end
        end
        // Last accumulate lands this cycle; psum is readable in CAPT.
        DRAIN: begin
          if (w_empty) begin
            r_state <= CAPT;
          end
        end
        CAPT: begin
          r_res_data  <= mac_psum;
          r_res_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign mem_req    = r_mem_req;
  assign mem_addr_a = r_addr_a;
  assign mem_addr_b = r_addr_b;
  assign mac_a      = mem_rdata_a;
  assign mac_b      = mem_rdata_b;
  assign mac_clear  = r_clear;
  assign mac_next   = w_next;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;

endmodule
